// File: rtl/rv_bus_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer that shares one memory bus between fetch and load/store.
// Optional wait-state timeout with a sticky FAULT state: define RV_BUS_SEQUENCER_TIMEOUT_EN.
module rv_bus_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [2:0]  FETCH_LENGTH   = 3'b010,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  input  logic        mem_ready,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_enable,
  output logic [2:0]  mem_write_length,
  input  logic [31:0] mem_read_data,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic [31:0] pc_next_in,
  input  logic [31:0] dp_bus_address,
  input  logic [31:0] dp_bus_wr_data,
  input  logic        dp_bus_wr_enable,
  input  logic [2:0]  dp_bus_write_length,
  output logic [31:0] dp_bus_read_data,
  output logic        commit,
  output logic [31:0] instret,
  output logic        fault
);

  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_WB
`ifdef RV_BUS_SEQUENCER_TIMEOUT_EN
    , ST_FAULT
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] instret_q, instret_d;
  logic        is_load, is_mem_op;
  logic        unused_bits;

`ifdef RV_BUS_SEQUENCER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_q, wait_d;
`endif

  assign is_load   = (instr_q[6:0] == OPC_LOAD);
  assign is_mem_op = is_load || (instr_q[6:0] == OPC_STORE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      rdata_q   <= '0;
      instret_q <= '0;
`ifdef RV_BUS_SEQUENCER_TIMEOUT_EN
      wait_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      rdata_q   <= rdata_d;
      instret_q <= instret_d;
`ifdef RV_BUS_SEQUENCER_TIMEOUT_EN
      wait_q    <= wait_d;
`endif
    end
  end

  // Bus outputs and commit are suppressed while reset is held so an abandoned
  // transfer drops mem_req in the cycle after the reset edge.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    instr_d          = instr_q;
    rdata_d          = rdata_q;
    instret_d        = instret_q;
    mem_req          = 1'b0;
    mem_address      = '0;
    mem_wr_data      = '0;
    mem_wr_enable    = 1'b0;
    mem_write_length = '0;
    commit           = 1'b0;
`ifdef RV_BUS_SEQUENCER_TIMEOUT_EN
    wait_d           = '0;
`endif
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_req          = 1'b1;
          mem_address      = pc_q;
          mem_write_length = FETCH_LENGTH;
          if (mem_ready) begin
            instr_d = mem_read_data;
            state_d = ST_EXEC;
          end
`ifdef RV_BUS_SEQUENCER_TIMEOUT_EN
          else begin
            wait_d = wait_q + 8'd1;
            if (wait_d == TIMEOUT_LIMIT) state_d = ST_FAULT;
          end
`endif
        end
        ST_EXEC: begin
          state_d = is_mem_op ? ST_MEM : ST_WB;
        end
        ST_MEM: begin
          mem_req          = 1'b1;
          mem_address      = dp_bus_address;
          mem_wr_data      = dp_bus_wr_data;
          mem_wr_enable    = dp_bus_wr_enable;
          mem_write_length = dp_bus_write_length;
          if (mem_ready) begin
            if (is_load) rdata_d = mem_read_data;
            state_d = ST_WB;
          end
`ifdef RV_BUS_SEQUENCER_TIMEOUT_EN
          else begin
            wait_d = wait_q + 8'd1;
            if (wait_d == TIMEOUT_LIMIT) state_d = ST_FAULT;
          end
`endif
        end
        ST_WB: begin
          commit    = 1'b1;
          pc_d      = {pc_next_in[31:2], 2'b00};
          instret_d = instret_q + 32'd1;
          state_d   = ST_FETCH;
        end
        default: state_d = state_q;
      endcase
    end
  end

`ifdef RV_BUS_SEQUENCER_TIMEOUT_EN
  assign fault       = !reset && (state_q == ST_FAULT);
  assign unused_bits = ^pc_next_in[1:0];
`else
  assign fault       = 1'b0;
  assign unused_bits = ^{pc_next_in[1:0], 8'(TIMEOUT_CYCLES)};
`endif

  assign instruction      = instr_q;
  assign pc               = pc_q;
  assign dp_bus_read_data = rdata_q;
  assign instret          = instret_q;

endmodule
